// File: rtl/painterengine_gpu_alpha_blender.sv
// ARGB8888 src-over-dst alpha blender with a 2-stage pipeline and a credit-guarded output FIFO.
// Optional macro PAINTERENGINE_GPU_BLEND_COLORKEY_EN adds i_wire_colorkey (src RGB match => alpha 0).
module painterengine_gpu_alpha_blender #(
  parameter int PARAM_FIFO_DEPTH = 8,
  parameter int PARAM_TIMEOUT    = 65535
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_resetn,
  input  logic        i_wire_start,
  input  logic [31:0] i_wire_length,
  input  logic [31:0] i_wire_src_data,
  input  logic        i_wire_src_valid,
  output logic        o_wire_src_next,
  input  logic [31:0] i_wire_dst_data,
  input  logic        i_wire_dst_valid,
  output logic        o_wire_dst_next,
`ifdef PAINTERENGINE_GPU_BLEND_COLORKEY_EN
  input  logic [23:0] i_wire_colorkey,
`endif
  output logic [31:0] o_wire_data,
  output logic        o_wire_data_valid,
  input  logic        i_wire_data_next,
  output logic        o_wire_done,
  output logic        o_wire_error,
  output logic [1:0]  o_wire_error_type
);
  localparam int AW = $clog2(PARAM_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W   = (CW+1)'(PARAM_FIFO_DEPTH);
  localparam logic [31:0] TIMEOUT_W = 32'(PARAM_TIMEOUT);

  typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE, ST_ERROR} state_t;

  state_t      state_q, state_d;
  logic [31:0] length_q, length_d;
  logic [31:0] in_cnt_q, in_cnt_d;
  logic [31:0] out_cnt_q, out_cnt_d;
  logic [31:0] timeout_q, timeout_d;
  logic [1:0]  err_type_q, err_type_d;

  logic          s1_valid_q, s2_valid_q;
  logic [7:0]    s1_src_a_q;
  logic [16:0]   s1_src_prod_q [3];
  logic [16:0]   s1_dst_prod_q [4];
  logic [31:0]   s2_data_q, blend_d;

  logic [31:0]   fifo_mem [PARAM_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] fifo_count_q;

  logic          take, pop, push, credit;
  logic [1:0]    inflight;
  logic [CW:0]   occupancy;
  logic [7:0]    eff_a;
  logic [8:0]    a_prime, inv_a;

  // Credit counts pixels already in the pipeline so the FIFO can never overflow.
  assign inflight  = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};
  assign occupancy = {1'b0, fifo_count_q} + {{(CW-1){1'b0}}, inflight};
  assign credit    = occupancy < DEPTH_W;
  assign take      = (state_q == ST_RUN) && i_wire_src_valid && i_wire_dst_valid && credit;
  assign pop       = o_wire_data_valid && i_wire_data_next;
  assign push      = s2_valid_q;

  assign o_wire_src_next   = take;
  assign o_wire_dst_next   = take;
  assign o_wire_data_valid = (fifo_count_q != '0);
  assign o_wire_data       = o_wire_data_valid ? fifo_mem[rd_ptr_q] : 32'd0;
  assign o_wire_done       = (state_q == ST_DONE);
  assign o_wire_error      = (state_q == ST_ERROR);
  assign o_wire_error_type = err_type_q;

`ifdef PAINTERENGINE_GPU_BLEND_COLORKEY_EN
  assign eff_a = (i_wire_src_data[23:0] == i_wire_colorkey) ? 8'd0 : i_wire_src_data[31:24];
`else
  assign eff_a = i_wire_src_data[31:24];
`endif
  // Bias by the MSB so alpha 255 maps to a full 256 weight.
  assign a_prime = {1'b0, eff_a} + {8'd0, eff_a[7]};
  assign inv_a   = 9'd256 - a_prime;

  always_comb begin
    state_d    = state_q;
    length_d   = length_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = pop ? out_cnt_q + 32'd1 : out_cnt_q;
    timeout_d  = timeout_q;
    err_type_d = err_type_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_wire_start) begin
          length_d  = i_wire_length;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          timeout_d = '0;
          if (i_wire_length == 32'd0) begin
            state_d    = ST_ERROR;
            err_type_d = 2'd1;
          end else begin
            state_d    = ST_RUN;
            err_type_d = 2'd0;
          end
        end
      end
      ST_RUN: begin
        if (take) begin
          in_cnt_d  = in_cnt_q + 32'd1;
          timeout_d = '0;
          if (in_cnt_d == length_q) state_d = ST_DRAIN;
        end else if (credit) begin
          timeout_d = timeout_q + 32'd1;
          if (timeout_d == TIMEOUT_W) begin
            state_d    = ST_ERROR;
            err_type_d = 2'd2;
          end
        end
      end
      ST_DRAIN: begin
        if (out_cnt_d == length_q) state_d = ST_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q    <= ST_IDLE;
      length_q   <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      timeout_q  <= '0;
      err_type_q <= '0;
    end else begin
      state_q    <= state_d;
      length_q   <= length_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      timeout_q  <= timeout_d;
      err_type_q <= err_type_d;
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      s1_valid_q <= 1'b0;
      s1_src_a_q <= '0;
      for (int i = 0; i < 3; i++) s1_src_prod_q[i] <= '0;
      for (int i = 0; i < 4; i++) s1_dst_prod_q[i] <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= take;
      if (take) begin
        s1_src_a_q <= eff_a;
        for (int i = 0; i < 3; i++)
          s1_src_prod_q[i] <= 17'(i_wire_src_data[8*i +: 8]) * 17'(a_prime);
        for (int i = 0; i < 4; i++)
          s1_dst_prod_q[i] <= 17'(i_wire_dst_data[8*i +: 8]) * 17'(inv_a);
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_data_q <= blend_d;
    end
  end

  always_comb begin
    blend_d = '0;
    blend_d[31:24] = s1_src_a_q + 8'(s1_dst_prod_q[3] >> 8);
    for (int i = 0; i < 3; i++)
      blend_d[8*i +: 8] = 8'((s1_src_prod_q[i] + s1_dst_prod_q[i]) >> 8);
  end

  always_ff @(posedge i_wire_clock) begin
    if (push) fifo_mem[wr_ptr_q] <= s2_data_q;
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + 1'b1;
        2'b01:   fifo_count_q <= fifo_count_q - 1'b1;
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_painterengine_gpu_alpha_blender.sv
// Directed bench for painterengine_gpu_alpha_blender: blend model queue, literal pins, FSM/error paths.
`timescale 1ns/1ps
module tb_painterengine_gpu_alpha_blender;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] length = '0;
  logic [31:0] src_data = '0, dst_data = '0;
  logic        src_valid = 1'b0, dst_valid = 1'b0;
  logic        src_next, dst_next;
  logic [31:0] o_data;
  logic        o_valid, data_next = 1'b0;
  logic        o_done, o_error;
  logic [1:0]  o_error_type;

  always #5 clk = ~clk;

  painterengine_gpu_alpha_blender dut (
    .i_wire_clock      (clk),
    .i_wire_resetn     (resetn),
    .i_wire_start      (start),
    .i_wire_length     (length),
    .i_wire_src_data   (src_data),
    .i_wire_src_valid  (src_valid),
    .o_wire_src_next   (src_next),
    .i_wire_dst_data   (dst_data),
    .i_wire_dst_valid  (dst_valid),
    .o_wire_dst_next   (dst_next),
`ifdef PAINTERENGINE_GPU_BLEND_COLORKEY_EN
    .i_wire_colorkey   (24'h5A5A5A),
`endif
    .o_wire_data       (o_data),
    .o_wire_data_valid (o_valid),
    .i_wire_data_next  (data_next),
    .o_wire_done       (o_done),
    .o_wire_error      (o_error),
    .o_wire_error_type (o_error_type)
  );

  int errors = 0, checks = 0, pops = 0;
  int takes, takes_hold, first_take, first_valid, end_cyc;
  logic valid_hold, got_out;
  logic [31:0] first_out;
  logic [31:0] exp_q[$];
  logic [31:0] src_arr[32], dst_arr[32];

  function automatic logic [31:0] blend(input logic [31:0] s, input logic [31:0] d);
    int a, ap;
    logic [31:0] res;
    a  = int'(s[31:24]);
    ap = (a >= 128) ? a + 1 : a;
    res = '0;
    res[31:24] = 8'(a + (int'(d[31:24]) * (256 - ap)) / 256);
    for (int c = 0; c < 3; c++)
      res[8*c +: 8] = 8'((int'(s[8*c +: 8]) * ap + int'(d[8*c +: 8]) * (256 - ap)) / 256);
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every accepted output pixel must be the next one the model predicts.
  always @(negedge clk) begin
    if (resetn) begin
      if (src_next || dst_next) check("src_dst_pair", {31'd0, dst_next}, {31'd0, src_next});
      if (o_valid && data_next) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output: got %h with no pixel outstanding", o_data);
        end else begin
          check("pixel", o_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    exp_q.delete();
  endtask

  task automatic start_job(input int len, input bit model);
    length = 32'(len);
    start  = 1'b1;
    pops   = 0;
    if (model) for (int i = 0; i < len; i++) exp_q.push_back(blend(src_arr[i], dst_arr[i]));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run(input int len, input int hold, input int abort_at, input bit feed, input int budget);
    int  idx;
    bit  took;
    idx = 0; takes = 0; takes_hold = -1; valid_hold = 1'b0;
    first_take = -1; first_valid = -1; got_out = 1'b0; first_out = '0; end_cyc = -1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (idx == abort_at) break;
      src_valid = feed && (idx < len);
      dst_valid = feed && (idx < len);
      src_data  = src_arr[idx % 32];
      dst_data  = dst_arr[idx % 32];
      data_next = (cyc >= hold);
      @(negedge clk);
      took = src_next;
      if (took) begin
        takes++;
        if (first_take < 0) first_take = cyc;
      end
      if (o_valid && first_valid < 0) first_valid = cyc;
      if (o_valid && data_next && !got_out) begin
        got_out   = 1'b1;
        first_out = o_data;
      end
      if (cyc == hold - 1) begin
        takes_hold = takes;
        valid_hold = o_valid;
      end
      @(posedge clk);
      #1;
      if (took) idx++;
      if (o_done || o_error) begin
        end_cyc = cyc;
        break;
      end
    end
    src_valid = 1'b0;
    dst_valid = 1'b0;
  endtask

  initial begin
    // Reset state, with inputs offered to prove nothing is consumed.
    src_valid = 1'b1; dst_valid = 1'b1; data_next = 1'b1;
    #3;
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_error", {31'd0, o_error}, 32'd0);
    check("rst_err_type", {30'd0, o_error_type}, 32'd0);
    check("rst_src_next", {31'd0, src_next}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1; src_valid = 1'b0; dst_valid = 1'b0;
    @(posedge clk); #1;

    // Opaque src: output equals src, latency 3.
    for (int i = 0; i < 4; i++) begin src_arr[i] = 32'hFF112233; dst_arr[i] = 32'h80AABBCC; end
    start_job(4, 1'b1);
    run(4, 0, -1, 1'b1, 200);
    check("t1_done", {31'd0, o_done}, 32'd1);
    check("t1_takes", 32'(takes), 32'd4);
    check("t1_pops", 32'(pops), 32'd4);
    check("t1_latency", 32'(first_valid - first_take), 32'd3);
    check("t1_literal", first_out, 32'hFF112233);
    check("t1_model_empty", 32'(exp_q.size()), 32'd0);

    // Transparent src: output equals dst. Restart from DONE.
    src_arr[0] = 32'h00FFFFFF; dst_arr[0] = 32'h40102030;
    start_job(1, 1'b1);
    run(1, 0, -1, 1'b1, 100);
    check("t2_done", {31'd0, o_done}, 32'd1);
    check("t2_literal", first_out, 32'h40102030);

    // Half alpha.
    src_arr[0] = 32'h80FF0000; dst_arr[0] = 32'hFF0000FF;
    start_job(1, 1'b1);
    run(1, 0, -1, 1'b1, 100);
    check("t3_done", {31'd0, o_done}, 32'd1);
    check("t3_literal", first_out, 32'hFE80007E);

    // Back-pressure: FIFO fills to depth, then everything drains in order.
    for (int i = 0; i < 20; i++) begin
      src_arr[i] = {8'(i*53+7), 8'(i*13), 8'(i*91+3), 8'(i*37+11)};
      dst_arr[i] = {8'(i*29+200), 8'(i*71+5), 8'(i*17+40), 8'(255-i*11)};
    end
    src_arr[0][31:24] = 8'hFF; src_arr[1][31:24] = 8'h00;
    src_arr[2][31:24] = 8'h80; src_arr[3][31:24] = 8'h7F;
    start_job(20, 1'b1);
    run(20, 40, -1, 1'b1, 400);
    check("t4_takes_held", 32'(takes_hold), 32'd8);
    check("t4_valid_held", {31'd0, valid_hold}, 32'd1);
    check("t4_takes", 32'(takes), 32'd20);
    check("t4_pops", 32'(pops), 32'd20);
    check("t4_done", {31'd0, o_done}, 32'd1);
    check("t4_model_empty", 32'(exp_q.size()), 32'd0);

    // Zero length -> error type 1, inputs not consumed.
    start_job(0, 1'b0);
    check("t5_zero_err", {31'd0, o_error}, 32'd1);
    check("t5_zero_type", {30'd0, o_error_type}, 32'd1);
    src_valid = 1'b1; dst_valid = 1'b1;
    #1;
    check("t5_err_no_take", {31'd0, src_next}, 32'd0);
    src_valid = 1'b0; dst_valid = 1'b0;
    do_reset();
    check("t5_err_cleared", {31'd0, o_error}, 32'd0);

    // Starved inputs -> timeout error type 2.
    start_job(2, 1'b0);
    run(2, 0, -1, 1'b0, 70000);
    check("t5_to_err", {31'd0, o_error}, 32'd1);
    check("t5_to_type", {30'd0, o_error_type}, 32'd2);
    check("t5_to_cycles", 32'(end_cyc + 1), 32'd65535);
    do_reset();

    // Reset mid-job, then a clean job.
    for (int i = 0; i < 10; i++) begin src_arr[i] = 32'h80000000 + 32'(i*32'h010203); dst_arr[i] = 32'h40FFFFFF; end
    start_job(10, 1'b1);
    run(10, 0, 3, 1'b1, 200);
    check("t6_before_abort", 32'(takes), 32'd3);
    src_valid = 1'b1; dst_valid = 1'b1;
    resetn = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, o_valid}, 32'd0);
    check("t6_rst_data", o_data, 32'd0);
    check("t6_rst_done", {31'd0, o_done}, 32'd0);
    check("t6_rst_src_next", {31'd0, src_next}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1; src_valid = 1'b0; dst_valid = 1'b0;
    exp_q.delete();
    start_job(2, 1'b1);
    run(2, 0, -1, 1'b1, 100);
    check("t6_done", {31'd0, o_done}, 32'd1);
    check("t6_pops", 32'(pops), 32'd2);
    check("t6_model_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
